// File: rtl/pipe_pkg.sv
// Shared definitions for the OTTER inter-stage skid buffer.
// Holds the buffer state encoding and its depth.
package pipe_pkg;

    // Buffer occupancy: main register empty, main only, or main plus skid.
    typedef enum logic [1:0] {
        EMPTY = 2'b00,
        BUSY  = 2'b01,
        FULL  = 2'b10
    } skid_state_t;

    // Number of words the buffer can hold (main + skid).
    localparam int SKID_DEPTH = 2;

endpackage

// File: rtl/reg_nb.sv
// Generic n-bit loadable register with asynchronous active-high clear.
// Loads data_in on a rising clk edge when ld is high; otherwise holds.
module reg_nb #(
    parameter int           n       = 32,
    parameter logic [n-1:0] RST_VAL = {n{1'b0}}
) (
    input  logic         clk,
    input  logic         clr,
    input  logic         ld,
    input  logic [n-1:0] data_in,
    output logic [n-1:0] data_out
);

    logic [n-1:0] data_r;

    // Storage element: async clear to RST_VAL, load on ld, else hold.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            data_r <= RST_VAL;
        end else if (ld) begin
            data_r <= data_in;
        end else begin
            data_r <= data_r;
        end
    end

    assign data_out = data_r;

endmodule

// File: rtl/pipe_skid_buf.sv
// Two-entry valid/ready skid buffer between OTTER pipeline stages.
// in_ready and out_valid are decoded purely from the registered state, so
// there is no combinational path from out_ready back to in_ready.
// Optional feature macro: PIPE_SKID_STALL_CNT_EN adds a saturating
// stall_cnt output counting cycles with out_valid=1 and out_ready=0.
module pipe_skid_buf
    import pipe_pkg::*;
#(
    parameter int           n       = 32,
    parameter logic [n-1:0] RST_VAL = {n{1'b0}}
) (
    input  logic         clk,
    input  logic         clr,
    input  logic         flush,
    input  logic [n-1:0] in_data,
    input  logic         in_valid,
    output logic         in_ready,
    output logic [n-1:0] out_data,
    output logic         out_valid,
`ifdef PIPE_SKID_STALL_CNT_EN
    output logic [31:0]  stall_cnt,
`endif
    input  logic         out_ready
);

    skid_state_t  state_r;
    skid_state_t  next_state_s;
    logic         out_valid_s;
    logic         in_ready_s;
    logic         in_fire_s;
    logic         out_fire_s;
    logic         main_ld_s;
    logic         skid_ld_s;
    logic [n-1:0] main_d_s;
    logic [n-1:0] skid_d_s;
    logic [n-1:0] main_q_s;
    logic [n-1:0] skid_q_s;

    assign in_fire_s  = in_valid & in_ready_s;
    assign out_fire_s = out_valid_s & out_ready;

    // State register: async clear to EMPTY.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_r <= EMPTY;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state logic; flush squashes any same-cycle handshake.
    always_comb begin
        next_state_s = state_r;
        if (flush) begin
            next_state_s = EMPTY;
        end else begin
            case (state_r)
                EMPTY: begin
                    if (in_fire_s) begin
                        next_state_s = BUSY;
                    end else begin
                        next_state_s = EMPTY;
                    end
                end
                BUSY: begin
                    if (in_fire_s && !out_fire_s) begin
                        next_state_s = FULL;
                    end else if (!in_fire_s && out_fire_s) begin
                        next_state_s = EMPTY;
                    end else begin
                        next_state_s = BUSY;
                    end
                end
                FULL: begin
                    if (out_fire_s) begin
                        next_state_s = BUSY;
                    end else begin
                        next_state_s = FULL;
                    end
                end
                default: begin
                    next_state_s = EMPTY;
                end
            endcase
        end
    end

    // Handshake outputs decoded from state only.
    always_comb begin
        out_valid_s = 1'b0;
        in_ready_s  = 1'b1;
        case (state_r)
            EMPTY: begin
                out_valid_s = 1'b0;
                in_ready_s  = 1'b1;
            end
            BUSY: begin
                out_valid_s = 1'b1;
                in_ready_s  = 1'b1;
            end
            FULL: begin
                out_valid_s = 1'b1;
                in_ready_s  = 1'b0;
            end
            default: begin
                out_valid_s = 1'b0;
                in_ready_s  = 1'b1;
            end
        endcase
    end

    // Load enables and data muxes for main/skid; flush reloads RST_VAL.
    always_comb begin
        main_ld_s = 1'b0;
        skid_ld_s = 1'b0;
        main_d_s  = in_data;
        skid_d_s  = in_data;
        if (flush) begin
            main_ld_s = 1'b1;
            skid_ld_s = 1'b1;
            main_d_s  = RST_VAL;
            skid_d_s  = RST_VAL;
        end else begin
            case (state_r)
                EMPTY: begin
                    main_ld_s = in_fire_s;
                end
                BUSY: begin
                    main_ld_s = in_fire_s & out_fire_s;
                    skid_ld_s = in_fire_s & ~out_fire_s;
                end
                FULL: begin
                    main_ld_s = out_fire_s;
                    main_d_s  = skid_q_s;
                end
                default: begin
                    main_ld_s = 1'b0;
                    skid_ld_s = 1'b0;
                end
            endcase
        end
    end

    reg_nb #(.n(n), .RST_VAL(RST_VAL)) u_main (
        .clk      (clk),
        .clr      (clr),
        .ld       (main_ld_s),
        .data_in  (main_d_s),
        .data_out (main_q_s)
    );

    reg_nb #(.n(n), .RST_VAL(RST_VAL)) u_skid (
        .clk      (clk),
        .clr      (clr),
        .ld       (skid_ld_s),
        .data_in  (skid_d_s),
        .data_out (skid_q_s)
    );

    assign out_data  = main_q_s;
    assign out_valid = out_valid_s;
    assign in_ready  = in_ready_s;

`ifdef PIPE_SKID_STALL_CNT_EN
    logic [31:0] stall_cnt_r;

    // Saturating stall counter; cleared by clr only, flush leaves it alone.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            stall_cnt_r <= 32'd0;
        end else if (out_valid_s && !out_ready && (stall_cnt_r != 32'hFFFF_FFFF)) begin
            stall_cnt_r <= stall_cnt_r + 32'd1;
        end else begin
            stall_cnt_r <= stall_cnt_r;
        end
    end

    assign stall_cnt = stall_cnt_r;
`endif

endmodule

// File: tb/tb_pipe_skid_buf.sv
// Directed self-checking bench for pipe_skid_buf.
// Inputs change 1 ns after each rising edge; outputs are sampled there too.
// Build with PIPE_SKID_STALL_CNT_EN defined to also check stall_cnt.
module tb_pipe_skid_buf;

    logic        clk;
    logic        clr;
    logic        flush;
    logic [31:0] in_data;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] out_data;
    logic        out_valid;
    logic        out_ready;
`ifdef PIPE_SKID_STALL_CNT_EN
    logic [31:0] stall_cnt;
`endif

    int n_cmp;
    int n_bad;

    pipe_skid_buf #(.n(32), .RST_VAL(32'h0000_0000)) dut (
        .clk       (clk),
        .clr       (clr),
        .flush     (flush),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
`ifdef PIPE_SKID_STALL_CNT_EN
        .stall_cnt (stall_cnt),
`endif
        .out_ready (out_ready)
    );

    // 10 ns clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %08h, want %08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_out(input string tag, input logic v, input logic r, input logic [31:0] d);
        check({tag, ".out_valid"}, {31'd0, out_valid}, {31'd0, v});
        check({tag, ".in_ready"},  {31'd0, in_ready},  {31'd0, r});
        check({tag, ".out_data"},  out_data, d);
    endtask

    initial begin
        n_cmp     = 0;
        n_bad     = 0;
        clr       = 1'b1;
        flush     = 1'b0;
        in_data   = 32'd0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        #1;
        check_out("reset", 1'b0, 1'b1, 32'h0000_0000);
        tick();
        clr = 1'b0;
        tick();
        check_out("idle", 1'b0, 1'b1, 32'h0000_0000);

        // 1. async clear mid-cycle, then first accept after release
        in_valid = 1'b1;
        in_data  = 32'hDEAD_BEEF;
        tick();
        check_out("t1.load", 1'b1, 1'b1, 32'hDEAD_BEEF);
        #2 clr = 1'b1;
        #1;
        check_out("t1.clr_now", 1'b0, 1'b1, 32'h0000_0000);
        tick();
        check_out("t1.clr_edge", 1'b0, 1'b1, 32'h0000_0000);
        #2 clr = 1'b0;
        tick();
        check_out("t1.first", 1'b1, 1'b1, 32'hDEAD_BEEF);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        check("t1.drain.out_valid", {31'd0, out_valid}, 32'd0);

        // 2. streaming with out_ready held high
        for (int i = 1; i <= 4; i++) begin
            in_valid = 1'b1;
            in_data  = i;
            tick();
            check_out($sformatf("t2.w%0d", i), 1'b1, 1'b1, i);
        end
        in_valid = 1'b0;
        tick();
        check("t2.end.out_valid", {31'd0, out_valid}, 32'd0);

        // 3. backpressure: 5 then 6 with out_ready low
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 32'd5;
        tick();
        check_out("t3.acc5", 1'b1, 1'b1, 32'd5);
        in_data = 32'd6;
        tick();
        check_out("t3.acc6", 1'b1, 1'b0, 32'd5);
        in_valid = 1'b0;
        tick();
        check_out("t3.hold", 1'b1, 1'b0, 32'd5);
        out_ready = 1'b1;
        tick();
        check_out("t3.out6", 1'b1, 1'b1, 32'd6);
        tick();
        check("t3.empty.out_valid", {31'd0, out_valid}, 32'd0);

        // 4. flush while FULL with a pending input
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 32'd7;
        tick();
        in_data = 32'd8;
        tick();
        check_out("t4.full", 1'b1, 1'b0, 32'd7);
        in_data = 32'd9;
        flush   = 1'b1;
        tick();
        check_out("t4.flushed", 1'b0, 1'b1, 32'h0000_0000);
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        check_out("t4.after", 1'b0, 1'b1, 32'h0000_0000);

        // 5. simultaneous in/out fire in BUSY
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 32'd10;
        tick();
        check_out("t5.busy10", 1'b1, 1'b1, 32'd10);
        out_ready = 1'b1;
        in_data   = 32'd11;
        tick();
        check_out("t5.busy11", 1'b1, 1'b1, 32'd11);
        in_valid = 1'b0;
        tick();
        check("t5.empty.out_valid", {31'd0, out_valid}, 32'd0);

`ifdef PIPE_SKID_STALL_CNT_EN
        // 6. stall counter: three stall cycles, survives flush
        clr = 1'b1;
        #1;
        check("t6.clr.stall_cnt", stall_cnt, 32'd0);
        tick();
        clr       = 1'b0;
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 32'd12;
        tick();
        in_valid = 1'b0;
        check("t6.s0.stall_cnt", stall_cnt, 32'd0);
        tick();
        tick();
        tick();
        check("t6.s3.stall_cnt", stall_cnt, 32'd3);
        flush     = 1'b1;
        out_ready = 1'b1;
        tick();
        flush = 1'b0;
        check("t6.flush.stall_cnt", stall_cnt, 32'd3);
        check("t6.flush.out_valid", {31'd0, out_valid}, 32'd0);
        tick();
        check("t6.keep.stall_cnt", stall_cnt, 32'd3);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
